// File: rtl/mesh_ni_packetizer.sv
// mesh_ni_packetizer
//   Terminal-side NoC transmitter. Takes a packet descriptor (destination
//   row/column, payload length) and a stream of payload words. Emits one
//   wormhole packet of HEAD, optional BODY flits, and TAIL on a valid/ready
//   terminal input channel of the 2D mesh.
//
// Ports
//   clk_i, rst_i        clock; synchronous active-high reset
//   pkt_vld_i/pkt_rdy_o descriptor handshake
//   pkt_dst_row_i       destination row
//   pkt_dst_col_i       destination column
//   pkt_len_i           number of payload flits
//   pld_data_i          payload word
//   pld_vld_i/pld_rdy_o payload handshake
//   flit_data_o         registered flit, {id, data}
//   flit_vld_o          registered flit valid
//   flit_rdy_i          NoC ready
//   pkt_sent_o          one-cycle pulse after the tail flit handshake
//   err_o               one-cycle pulse after an out-of-range descriptor
module mesh_ni_packetizer #(
  parameter  int ROW_N       = 3,
  parameter  int COL_M       = 3,
  parameter  int CHANNEL_W   = 8,
  parameter  int FLIT_ID_W   = 2,
  parameter  int LEN_W       = 4,
  localparam int ROW_ADDR_W  = (ROW_N > 1) ? $clog2(ROW_N) : 1,
  localparam int COL_ADDR_W  = (COL_M > 1) ? $clog2(COL_M) : 1,
  localparam int FLIT_DATA_W = CHANNEL_W - FLIT_ID_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   pkt_vld_i,
  output logic                   pkt_rdy_o,
  input  logic [ROW_ADDR_W-1:0]  pkt_dst_row_i,
  input  logic [COL_ADDR_W-1:0]  pkt_dst_col_i,
  input  logic [LEN_W-1:0]       pkt_len_i,
  input  logic [FLIT_DATA_W-1:0] pld_data_i,
  input  logic                   pld_vld_i,
  output logic                   pld_rdy_o,
  output logic [CHANNEL_W-1:0]   flit_data_o,
  output logic                   flit_vld_o,
  input  logic                   flit_rdy_i,
  output logic                   pkt_sent_o,
  output logic                   err_o
);

  localparam logic [FLIT_ID_W-1:0] ID_HEAD = FLIT_ID_W'(1);
  localparam logic [FLIT_ID_W-1:0] ID_BODY = FLIT_ID_W'(2);
  localparam logic [FLIT_ID_W-1:0] ID_TAIL = FLIT_ID_W'(3);

  // One extra bit so a power-of-two mesh dimension is still representable.
  localparam logic [ROW_ADDR_W:0] ROW_LIM = (ROW_ADDR_W + 1)'(ROW_N);
  localparam logic [COL_ADDR_W:0] COL_LIM = (COL_ADDR_W + 1)'(COL_M);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BODY,
    ST_ZTAIL
  } state_t;

  state_t state_q, state_d;

  logic [LEN_W-1:0]       remaining_q;
  logic                   out_free;
  logic                   dst_ok;
  logic                   pkt_hs;
  logic                   pld_hs;
  logic                   load_head;
  logic                   load_ztail;
  logic                   last_pld;
  logic [FLIT_DATA_W-1:0] head_data;
  logic [FLIT_ID_W-1:0]   out_id;

  // Output register can take a new flit when empty or draining this cycle.
  assign out_free = !flit_vld_o || flit_rdy_i;
  assign out_id   = flit_data_o[CHANNEL_W-1 -: FLIT_ID_W];

  always_comb begin
    dst_ok = ({1'b0, pkt_dst_row_i} < ROW_LIM) && ({1'b0, pkt_dst_col_i} < COL_LIM);
    head_data = '0;
    head_data[COL_ADDR_W-1:0]          = pkt_dst_col_i;
    head_data[COL_ADDR_W +: ROW_ADDR_W] = pkt_dst_row_i;
    pkt_hs     = pkt_vld_i && pkt_rdy_o;
    pld_hs     = pld_vld_i && pld_rdy_o;
    load_head  = pkt_hs && dst_ok;
    load_ztail = (state_q == ST_ZTAIL) && out_free;
    last_pld   = (remaining_q == LEN_W'(1));
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load_head) begin
          state_d = (pkt_len_i == '0) ? ST_ZTAIL : ST_BODY;
        end
      end
      ST_BODY: begin
        if (pld_hs && last_pld) begin
          state_d = ST_IDLE;
        end
      end
      ST_ZTAIL: begin
        if (out_free) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    pkt_rdy_o = 1'b0;
    pld_rdy_o = 1'b0;
    unique case (state_q)
      ST_IDLE:  pkt_rdy_o = out_free;
      ST_BODY:  pld_rdy_o = out_free;
      ST_ZTAIL: ;
      default:  ;
    endcase
  end

  // Flit output register, remaining counter and event pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flit_data_o <= '0;
      flit_vld_o  <= 1'b0;
      remaining_q <= '0;
      pkt_sent_o  <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      pkt_sent_o <= flit_vld_o && flit_rdy_i && (out_id == ID_TAIL);
      err_o      <= pkt_hs && !dst_ok;
      if (load_head) begin
        flit_data_o <= {ID_HEAD, head_data};
        flit_vld_o  <= 1'b1;
        remaining_q <= pkt_len_i;
      end else if (pld_hs) begin
        flit_data_o <= {(last_pld ? ID_TAIL : ID_BODY), pld_data_i};
        flit_vld_o  <= 1'b1;
        remaining_q <= remaining_q - LEN_W'(1);
      end else if (load_ztail) begin
        flit_data_o <= {ID_TAIL, {FLIT_DATA_W{1'b0}}};
        flit_vld_o  <= 1'b1;
      end else if (flit_rdy_i) begin
        flit_vld_o  <= 1'b0;
      end
    end
  end

endmodule
